aes_round_engine: RTL

// - Iterative AES-128 encryption datapath; the direct consumer of wholekeyexpand's round-key bus.
// - Takes a 16-byte plaintext state plus the cipher key and the 160-byte expanded round-key bus.
// - Performs the initial AddRoundKey, then rounds 1..10 at one round per clk.
// - Returns the 16-byte ciphertext over a valid/ready handshake.

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/aes_round_engine_if.sv | 24 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_round_engine.sv | 108 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 round engine.
// Byte layout everywhere: byte index = 15-(4*row+col), so row 0 occupies the top four bytes.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [15:0][7:0]  aes_block_t;
    typedef logic [159:0][7:0] aes_rkbus_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column packed as {row0, row1, row2, row3}.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    function automatic aes_block_t mix_columns(input aes_block_t s);
        aes_block_t  res;
        logic [31:0] col;
        for (int c = 0; c < 4; c++) begin
            col         = mix_column({s[15-c], s[11-c], s[7-c], s[3-c]});
            res[15-c]   = col[31:24];
            res[11-c]   = col[23:16];
            res[7-c]    = col[15:8];
            res[3-c]    = col[7:0];
        end
        return res;
    endfunction

    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t res;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res[15-(4*r+c)] = s[15-(4*r+((c+r)%4))];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Plaintext/key/round-key request and ciphertext response channels of the round engine.
interface aes_round_engine_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t state;
    aes_block_t key;
    aes_rkbus_t rk;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out;

    modport master (
        output in_valid, state, key, rk, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, state, key, rk, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, its substitution out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] subst
);

    assign subst = SBOX[value];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 cipher: initial AddRoundKey on accept, then one full round per clock.
// Round keys are taken straight off the unregistered rk bus, so its producer holds it while running.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR       = aes_pkg::NR,
    parameter int RK_BYTES = 160
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_engine_if.slave bus
);

    localparam int         RK_ROUNDS  = RK_BYTES / 16;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t       fsm;
    logic [3:0] round;
    aes_block_t s;
    logic       ready;
    logic       valid;

    aes_block_t sub;
    aes_block_t shifted;
    aes_block_t mixed;
    aes_block_t round_key;
    aes_block_t next_s;
    logic       last_round;
    logic       round_ok;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .value (s[i]),
            .subst (sub[i])
        );
    end

    // Round k uses bytes 16k-1 down to 16k-16 of the key bus.
    always_comb begin
        shifted    = shift_rows(sub);
        mixed      = mix_columns(shifted);
        round_key  = '0;
        for (int k = 1; k <= RK_ROUNDS; k++) begin
            if (round == 4'(k)) begin
                round_key = bus.rk[16*k-1 -: 16];
            end
        end
        last_round = (round == LAST_ROUND);
        round_ok   = (round != 4'd0) && (round <= LAST_ROUND);
        next_s     = (last_round ? shifted : mixed) ^ round_key;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm   <= IDLE;
            round <= 4'd0;
            s     <= '0;
            ready <= 1'b1;
            valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        s     <= bus.state ^ bus.key;
                        round <= 4'd1;
                        fsm   <= RUN;
                        ready <= 1'b0;
                    end
                end
                RUN: begin
                    // An out-of-range counter can only come from corruption; fall back to idle.
                    if (!round_ok) begin
                        fsm   <= IDLE;
                        round <= 4'd0;
                        ready <= 1'b1;
                    end else begin
                        s <= next_s;
                        if (last_round) begin
                            fsm   <= DONE;
                            round <= 4'd0;
                            valid <= 1'b1;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm   <= IDLE;
                        valid <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    round <= 4'd0;
                    ready <= 1'b1;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out       = s;

endmodule
